// File: rtl/regfile_wr_arbiter_if.sv
// Write-request and register-file write-port bundle for regfile_wr_arbiter.
// master = requesters / register file side, slave = arbiter.
interface regfile_wr_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              regWrite;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  regWrite, writeReg, writeData
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output regWrite, writeReg, writeData
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-port arbiter for the register-file write port: WB stage (port 0) vs long-latency unit (port 1).
// Define REGFILE_WR_ARB_RR_EN for round-robin; default is port-0 priority with a port-1 starvation limit.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
`ifndef REGFILE_WR_ARB_RR_EN
  , parameter int unsigned STARVE_MAX = 4
`endif
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);

  logic              grant0;
  logic              grant1;
  logic              port1Turn;
  logic              xfer;
  logic [ADDR_W-1:0] winReg;
  logic [DATA_W-1:0] winData;
  logic              regWriteQ;
  logic [ADDR_W-1:0] writeRegQ;
  logic [DATA_W-1:0] writeDataQ;

`ifdef REGFILE_WR_ARB_RR_EN
  logic rrLast;

  // Port 1 wins a tie only when port 0 was granted last.
  assign port1Turn = !rrLast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rrLast <= 1'b1;
    else if (xfer) rrLast <= grant1;
  end
`else
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starveCnt;

  assign port1Turn = (starveCnt == STARVE_LIM);

  // Counts consecutive denied port-1 cycles; any non-waiting cycle clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (bus.req1_valid && !grant1) begin
      if (starveCnt != STARVE_LIM) starveCnt <= starveCnt + CNT_W'(1);
    end else begin
      starveCnt <= '0;
    end
  end
`endif

  always_comb begin
    grant1  = !rst && bus.req1_valid && (!bus.req0_valid || port1Turn);
    grant0  = !rst && bus.req0_valid && !grant1;
    xfer    = grant0 || grant1;
    winReg  = grant1 ? bus.req1_reg  : bus.req0_reg;
    winData = grant1 ? bus.req1_data : bus.req0_data;
  end

  // Register-file write stage; writes to r0 complete the handshake but never assert regWrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regWriteQ  <= 1'b0;
      writeRegQ  <= '0;
      writeDataQ <= '0;
    end else begin
      regWriteQ <= xfer && (winReg != '0);
      if (xfer) begin
        writeRegQ  <= winReg;
        writeDataQ <= winData;
      end
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.regWrite   = regWriteQ;
  assign bus.writeReg   = writeRegQ;
  assign bus.writeData  = writeDataQ;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a cycle-level model of the arbitration rules.
// Honours REGFILE_WR_ARB_RR_EN the same way as the design.
module tb_regfile_wr_arbiter;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int          STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  // Model state: waited cycles of port 1, last-granted port, and the write-port image.
  int          mWaited;
  int          mLast;
  bit          mWe;
  logic [4:0]  mReg;
  logic [31:0] mData;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mWaited = 0;
    mLast   = 1;
    mWe     = 1'b0;
    mReg    = '0;
    mData   = '0;
  endtask

  task automatic driveIdle();
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
  endtask

  // Called at a falling edge: drive requests, check readies, cross one rising edge, check write port.
  task automatic stepCycle(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                           input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                           output bit g0, output bit g1, output bit obs1);
    bit turn1;
    bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
    #1;
`ifdef REGFILE_WR_ARB_RR_EN
    turn1 = (mLast == 0);
`else
    turn1 = (mWaited >= STARVE_MAX);
`endif
    g1   = v1 && (!v0 || turn1);
    g0   = v0 && !g1;
    obs1 = bus.req1_ready;
    checkEq("req0_ready", 32'(bus.req0_ready), 32'(g0));
    checkEq("req1_ready", 32'(bus.req1_ready), 32'(g1));
    @(posedge clk);
    if (g0 || g1) begin
      mReg  = g1 ? r1 : r0;
      mData = g1 ? d1 : d0;
      mWe   = (mReg != 5'd0);
      mLast = g1 ? 1 : 0;
    end else begin
      mWe = 1'b0;
    end
    if (v1 && !g1) mWaited = (mWaited + 1 > STARVE_MAX) ? STARVE_MAX : mWaited + 1;
    else           mWaited = 0;
    @(negedge clk);
    checkEq("regWrite",  32'(bus.regWrite),  32'(mWe));
    checkEq("writeReg",  32'(bus.writeReg),  32'(mReg));
    checkEq("writeData", bus.writeData, mData);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    driveIdle();
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit          g0, g1, o1;
  bit          p0v, p1v;
  logic [4:0]  p0r, p1r;
  logic [31:0] p0d, p1d;

  initial begin
    modelReset();
    driveIdle();
    bus.req0_valid = 1'b1;
    bus.req0_reg   = 5'd3;
    repeat (2) @(negedge clk);
    checkEq("rst_ready0",    32'(bus.req0_ready), 32'd0);
    checkEq("rst_ready1",    32'(bus.req1_ready), 32'd0);
    checkEq("rst_regWrite",  32'(bus.regWrite),   32'd0);
    checkEq("rst_writeReg",  32'(bus.writeReg),   32'd0);
    checkEq("rst_writeData", bus.writeData,       32'd0);
    rst = 1'b0;
    #1;
    checkEq("rel_ready0", 32'(bus.req0_ready), 32'd1);
    driveIdle();
    @(negedge clk);

    // Single write followed by an idle cycle
    stepCycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, g0, g1, o1);
    checkEq("single_we",   32'(bus.regWrite), 32'd1);
    checkEq("single_reg",  32'(bus.writeReg), 32'd5);
    checkEq("single_data", bus.writeData,     32'hDEADBEEF);
    stepCycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, g0, g1, o1);
    checkEq("idle_we", 32'(bus.regWrite), 32'd0);

    // Write to r0 handshakes but does not write
    stepCycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, g0, g1, o1);
    checkEq("r0_ready1", 32'(o1),             32'd1);
    checkEq("r0_we",     32'(bus.regWrite),   32'd0);

    // Continuous contention from a clean reset
    applyReset();
    for (int i = 0; i < 6; i++) begin
      stepCycle(1'b1, 5'(i + 1), 32'(i * 16 + 1), 1'b1, 5'd7, 32'(32'h7700 + i), g0, g1, o1);
`ifdef REGFILE_WR_ARB_RR_EN
      checkEq("contend_g1", 32'(o1), 32'(i % 2 == 1));
`else
      checkEq("contend_g1", 32'(o1), 32'(i == STARVE_MAX));
`endif
    end

    // Reset mid-flight discards the pending write and arbitration state
    stepCycle(1'b1, 5'd2, 32'h22, 1'b1, 5'd4, 32'h44, g0, g1, o1);
    stepCycle(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, g0, g1, o1);
    bus.req0_valid = 1'b1; bus.req0_reg = 5'd9; bus.req0_data = 32'h99;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    driveIdle();
    #1;
    checkEq("midrst_we",  32'(bus.regWrite), 32'd0);
    checkEq("midrst_reg", 32'(bus.writeReg), 32'd0);
    modelReset();
    @(negedge clk);
    checkEq("midrst_ready0", 32'(bus.req0_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stepCycle(1'b1, 5'(i + 10), 32'(i), 1'b1, 5'd11, 32'hB0B0, g0, g1, o1);
    end

    // Randomized traffic obeying the hold-until-transfer rule
    p0v = 1'b0; p1v = 1'b0;
    p0r = '0; p1r = '0; p0d = '0; p1d = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!p0v && $urandom_range(3) != 0) begin
        p0v = 1'b1; p0r = 5'($urandom_range(31)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(3) != 0) begin
        p1v = 1'b1; p1r = 5'($urandom_range(31)); p1d = $urandom;
      end
      stepCycle(p0v, p0r, p0d, p1v, p1r, p1d, g0, g1, o1);
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the single write port of the 32x32 general-purpose register file between two writeback requesters: the main pipeline WB stage (port 0) and the multi-cycle multiply/divide/load-miss unit (port 1). Requesters use a valid/ready handshake. Each accepted write is registered once and driven onto the register-file write port (writeReg/writeData/regWrite) the following cycle. The block sits between the WB-stage mux and the register file. Its ready outputs are the stall sources for the pipeline and the long-latency unit.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STARVE_MAX, 4, consecutive port-1 denials before port 1 is forced to win (fixed-priority mode only); legal range 1..15
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- req0_valid  input  1  port 0 write request
- req0_reg  input  ADDR_W  port 0 destination register
- req0_data  input  DATA_W  port 0 write data
- req0_ready  output  1  port 0 granted this cycle (combinational)
- req1_valid  input  1  port 1 write request
- req1_reg  input  ADDR_W  port 1 destination register
- req1_data  input  DATA_W  port 1 write data
- req1_ready  output  1  port 1 granted this cycle (combinational)
- regWrite  output  1  register-file write enable (registered)
- writeReg  output  ADDR_W  register-file write address (registered)
- writeData  output  DATA_W  register-file write data (registered)

## Operation
- Handshake: a transfer on port N occurs on a rising edge where reqN_valid && reqN_ready. At most one grant per cycle, so req0_ready && req1_ready is never 1.
- Requester rules: after raising valid, the requester holds reg/data stable until the transfer. It must not drop valid before the transfer.
- The ready outputs depend only on valid inputs and internal state, never on reg/data. The same-cycle valid-to-ready path is combinational.
- Single requester valid: that requester is granted unconditionally.
- Both valid: the winner is set by the arbitration policy (see Configuration).
- Fixed-priority mode, starvation counter starve_cnt (width 4):
  - Port 0 wins by default.
  - starve_cnt increments, saturating at STARVE_MAX, on every edge where req1_valid && !req1_ready.
  - starve_cnt clears to 0 on a port-1 transfer or whenever req1_valid=0.
  - When starve_cnt == STARVE_MAX, port 1 wins the current cycle.
- Writes to register 0: the handshake completes normally and counts as a grant for fairness state. regWrite stays 0 for that slot.
- Output stage, on each edge:
  - With a transfer: writeReg/writeData load the winner's reg/data, and regWrite loads (winner reg != 0).
  - Without a transfer: regWrite loads 0, and writeReg/writeData hold their previous values.
- No combining or ordering of same-register writes across ports. Write-after-write ordering is the requesters' responsibility.

## Timing
- Reset values: regWrite=0, writeReg=0, writeData=0, starve_cnt=0, rr_last=1 (port 0 preferred first).
- While rst=1: req0_ready=0 and req1_ready=0, and no transfer occurs.
- Reset asserted mid-operation discards any registered write. regWrite drops to 0 asynchronously.
- Latency:
  - Transfer at edge T gives regWrite=1 during cycle T..T+1.
  - The register file captures the write at edge T+1.
  - The value is readable from the register file after T+1.
- Throughput: one write per cycle sustained. Back-to-back grants to the same or alternating ports are permitted with no bubble.
- Port-1 worst-case wait under continuous port-0 traffic:
  - Fixed-priority mode: STARVE_MAX denied cycles, then granted.
  - Round-robin mode: 1 denied cycle.

## Configuration
- Macro: REGFILE_WR_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Pointer rr_last records the last-granted port.
  - When both are valid, the port != rr_last wins.
  - rr_last updates on every transfer. starve_cnt and STARVE_MAX are not implemented.
- Undefined: fixed priority to port 0 with the starvation counter described under Operation. rr_last is not implemented.

## Test plan
- Reset: assert rst with req0_valid=1 -> both readies 0, regWrite=0, writeReg=0, writeData=0. Deassert rst -> req0_ready=1 in the same cycle.
- Single write: req0_valid=1, req0_reg=5, req0_data=0xDEADBEEF for one cycle -> the next cycle has regWrite=1, writeReg=5, writeData=0xDEADBEEF. The cycle after has regWrite=0.
- Register 0: req1_valid=1, req1_reg=0, req1_data=0x1234 -> req1_ready=1, and regWrite stays 0 on the following cycle.
- Contention, fixed priority (STARVE_MAX=4): both valid continuously, with port 0 changing reg each cycle -> port 0 granted for 4 cycles, port 1 granted on the 5th, and starve_cnt returns to 0.
- Contention, REGFILE_WR_ARB_RR_EN defined: both valid from reset -> grants alternate 0,1,0,1.
- Reset mid-flight: transfer at edge T, then rst asserted before edge T+1 -> regWrite falls to 0 immediately. No write reaches the register file, and rr_last/starve_cnt are at reset values.
